// File: rtl/position_calc_pkg.sv
// Shared types and helpers for the multi-axis position calculator.
package position_calc_pkg;

  typedef enum logic [1:0] {
    MODE_NO_FILTERING = 2'd0,
    MODE_FILTERING    = 2'd1,
    MODE_REMOVE_DRIFT = 2'd2
  } mode_e;

  // Widest frame the packing helper can build; callers truncate to their own width.
  localparam int PACK_W = 128;

  // Clamp a wide signed value into the signed range of a w-bit word (w <= 31).
  function automatic logic signed [31:0] sat_clamp(input logic signed [32:0] v,
                                                   input int unsigned w);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (v > hi)      return 32'(hi);
    else if (v < lo) return 32'(lo);
    else             return 32'(v);
  endfunction

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    return sat_clamp(33'(a) + 33'(b), w);
  endfunction

  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    return sat_clamp(33'(a) - 33'(b), w);
  endfunction

  // Places the frame counter in the LSBs with the position words above it.
  function automatic logic [PACK_W-1:0] pack_frame(input logic [PACK_W-1:0] pos_bits,
                                                   input logic [31:0] frame,
                                                   input int unsigned frame_w);
    return (pos_bits << frame_w) | PACK_W'(frame);
  endfunction

endpackage

// File: rtl/pos_moving_average.sv
// Moving-average filter for one axis: circular history plus running sum.
// A window change (new aveLog2 on a pushed sample) restarts the history from that sample.
module pos_moving_average
  import position_calc_pkg::*;
#(
  parameter int POSTI_BIT_WIDTH = 16,
  parameter int MAX_AVE_LOG2    = 6
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     clear,
  input  logic                                     push,
  input  logic [$clog2(MAX_AVE_LOG2+1)-1:0]        ave,
  input  logic signed [POSTI_BIT_WIDTH-1:0]        din,
  output logic signed [POSTI_BIT_WIDTH-1:0]        avg
);

  localparam int W     = POSTI_BIT_WIDTH;
  localparam int DEPTH = 1 << MAX_AVE_LOG2;
  localparam int SW    = W + MAX_AVE_LOG2;
  localparam int PW    = MAX_AVE_LOG2 + 1;
  localparam int AW    = $clog2(MAX_AVE_LOG2 + 1);

  logic signed [W-1:0]      hist_q [DEPTH];
  logic [MAX_AVE_LOG2-1:0]  wr_ptr;
  logic [MAX_AVE_LOG2-1:0]  rd_ptr;
  logic [PW-1:0]            window;
  logic signed [SW-1:0]     sum_q;
  logic signed [SW-1:0]     shifted;
  logic [AW-1:0]            cur_ave;

  // The entry leaving the window sits 2**ave slots behind the write pointer.
  assign window  = PW'(1) << ave;
  assign rd_ptr  = MAX_AVE_LOG2'({1'b0, wr_ptr} - window);
  assign shifted = sum_q >>> cur_ave;
  assign avg     = W'(shifted);

  // History, running sum and active window size.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q   <= '0;
      wr_ptr  <= '0;
      cur_ave <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q <= '0;
    end else if (push) begin
      if (ave != cur_ave) begin
        for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        hist_q[wr_ptr] <= din;
        sum_q          <= SW'(din);
        cur_ave        <= ave;
      end else begin
        hist_q[wr_ptr] <= din;
        sum_q          <= sum_q + SW'(din) - SW'(hist_q[rd_ptr]);
      end
      wr_ptr <= wr_ptr + MAX_AVE_LOG2'(1);
    end
  end

endmodule

// File: rtl/multi_axis_position_calculator.sv
// Multi-axis position calculator: step decode, saturating accumulators,
// per-axis moving average, mode mux and a single-slot valid/ready output.
module multi_axis_position_calculator
  import position_calc_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int DETC_DATA_WIDTH = 16,
  parameter int POSTI_BIT_WIDTH = 16,
  parameter int FRAME_BIT_WIDTH = 16,
  parameter int MAX_AVE_LOG2    = 6,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                                          clk,
  input  logic                                          n_rst,
  input  logic                                          startFlag,
  input  logic                                          clearAccum,
  input  logic [POSTI_BIT_WIDTH-1:0]                    constValue,
  input  logic [NUM_CH*DETC_DATA_WIDTH-1:0]             detcData,
  input  logic [2*NUM_CH-1:0]                           Mode_PostiData,
  input  logic [$clog2(MAX_AVE_LOG2+1)-1:0]             aveLog2,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_CH*POSTI_BIT_WIDTH+FRAME_BIT_WIDTH-1:0] SendData,
  output logic [FRAME_BIT_WIDTH-1:0]                    frameNum,
  output logic [DROP_CNT_WIDTH-1:0]                     dropCount
);

  localparam int W   = POSTI_BIT_WIDTH;
  localparam int D   = DETC_DATA_WIDTH;
  localparam int AW  = $clog2(MAX_AVE_LOG2 + 1);
  localparam int SDW = NUM_CH * W + FRAME_BIT_WIDTH;

  logic                 s1_valid;
  logic                 s1_clear;
  logic [2*NUM_CH-1:0]  s1_mode;
  logic [AW-1:0]        s1_ave;
  logic signed [W-1:0]  s1_step   [NUM_CH];
  logic                 s2_valid;
  logic [2*NUM_CH-1:0]  s2_mode;
  logic signed [W-1:0]  accum     [NUM_CH];
  logic signed [W-1:0]  accum_nxt [NUM_CH];
  logic signed [W-1:0]  avg_w     [NUM_CH];
  logic [NUM_CH*W-1:0]  pos_vec;

  // Capture stage: decode steps and latch per-frame settings; clear beats start.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_clear <= 1'b0;
      s1_mode  <= '0;
      s1_ave   <= '0;
      for (int i = 0; i < NUM_CH; i++) s1_step[i] <= '0;
    end else begin
      s1_valid <= startFlag && !clearAccum;
      s1_clear <= clearAccum;
      s1_mode  <= Mode_PostiData;
      s1_ave   <= (aveLog2 > AW'(MAX_AVE_LOG2)) ? AW'(MAX_AVE_LOG2) : aveLog2;
      for (int i = 0; i < NUM_CH; i++) begin
        if (detcData[i*D +: D] == '0)   s1_step[i] <= '0;
        else if (detcData[i*D + D - 1]) s1_step[i] <= -$signed(constValue);
        else                            s1_step[i] <= $signed(constValue);
      end
    end
  end

  // Next accumulator value, shared by the accumulator and the filter push.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      accum_nxt[i] = W'(sat_add(32'(accum[i]), 32'(s1_step[i]), W));
  end

  // Accumulate stage. The clear acts one cycle late so a frame already past
  // capture still reads the pre-clear accumulator at the output stage.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s2_valid <= 1'b0;
      s2_mode  <= '0;
      for (int i = 0; i < NUM_CH; i++) accum[i] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      for (int i = 0; i < NUM_CH; i++) begin
        if (s1_clear)      accum[i] <= '0;
        else if (s1_valid) accum[i] <= accum_nxt[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pos_moving_average #(
      .POSTI_BIT_WIDTH (POSTI_BIT_WIDTH),
      .MAX_AVE_LOG2    (MAX_AVE_LOG2)
    ) u_ma (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (s1_clear),
      .push  (s1_valid),
      .ave   (s1_ave),
      .din   (accum_nxt[g]),
      .avg   (avg_w[g])
    );
  end

  // Per-channel output selection.
  always_comb begin
    pos_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (s2_mode[2*i +: 2])
        MODE_NO_FILTERING: pos_vec[i*W +: W] = accum[i];
        MODE_FILTERING:    pos_vec[i*W +: W] = avg_w[i];
        MODE_REMOVE_DRIFT: pos_vec[i*W +: W] = W'(sat_sub(32'(accum[i]), 32'(avg_w[i]), W));
        default:           pos_vec[i*W +: W] = '0;
      endcase
    end
  end

  // Output slot: load when free or draining, otherwise drop and count.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      SendData  <= '0;
      frameNum  <= '0;
      dropCount <= '0;
    end else if (s2_valid) begin
      frameNum <= frameNum + FRAME_BIT_WIDTH'(1);
      if (!out_valid || out_ready) begin
        SendData  <= SDW'(pack_frame(PACK_W'(pos_vec), 32'(frameNum), FRAME_BIT_WIDTH));
        out_valid <= 1'b1;
      end else if (dropCount != '1) begin
        dropCount <= dropCount + DROP_CNT_WIDTH'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
